// File: rtl/cic_readout_pkg.sv
// Shared definitions for the CIC filter row readout.
//   NUM_CHANNELS_DEF / DATA_WIDTH_DEF : default frame geometry
//   CHAN_W, HEADER_CHAN              : channel tag width and header tag value
//   FRAME_CNT_W                      : width of the optional frame counter
//   state_e                          : readout FSM states
package cic_readout_pkg;

  localparam int unsigned NUM_CHANNELS_DEF = 24;
  localparam int unsigned DATA_WIDTH_DEF   = 25;

  localparam int unsigned CHAN_W      = 5;
  localparam logic [CHAN_W-1:0] HEADER_CHAN = 5'h1F;

  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StSend = 2'd2
  } state_e;

endpackage

// File: rtl/cic_row_readout.sv
// Captures one decimated sample set from a bank of CIC filters into a shadow
// bank and streams it out one word per transfer over a valid/ready port.
//
// Ports:
//   clk_i           : modulator clock, rising edge
//   reset_ni        : asynchronous active-low reset
//   filt_data_i     : concatenated filter outputs, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   filt_strobe_i   : one-cycle pulse, filt_data_i holds a new sample set
//   enable_i        : high to accept new frames
//   clear_overrun_i : synchronous clear of overrun_o
//   rd_data_o       : current output word
//   rd_chan_o       : channel of rd_data_o (HEADER_CHAN for the header word)
//   rd_valid_o      : output word valid
//   rd_ready_i      : consumer accepts; transfer on rd_valid_o && rd_ready_i
//   rd_last_o       : final word of the frame
//   overrun_o       : sticky, a strobe arrived while a frame was still busy
//
// Build option: define CIC_READOUT_HEADER_EN to prefix each frame with a header
// word carrying an 8-bit wrapping frame counter.
module cic_row_readout
  import cic_readout_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] filt_data_i,
  input  logic                               filt_strobe_i,
  input  logic                               enable_i,
  input  logic                               clear_overrun_i,
  output logic [DATA_WIDTH-1:0]              rd_data_o,
  output logic [CHAN_W-1:0]                  rd_chan_o,
  output logic                               rd_valid_o,
  input  logic                               rd_ready_i,
  output logic                               rd_last_o,
  output logic                               overrun_o
);

  localparam logic [CHAN_W-1:0] LastIdx = CHAN_W'(NUM_CHANNELS - 1);

  state_e                  state_q;
  logic [CHAN_W-1:0]       idx_q;
  logic [DATA_WIDTH-1:0]   shadow_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [CHAN_W-1:0]       rd_chan_q;
  logic                    rd_valid_q;
  logic                    rd_last_q;
  logic                    overrun_q;
`ifdef CIC_READOUT_HEADER_EN
  logic [FRAME_CNT_W-1:0]  frame_cnt_q;
`endif

  logic              xfer;
  logic              last_xfer;
  logic              accept;
  logic              drop;
  logic [CHAN_W-1:0] idx_nxt;

  always_comb begin
    xfer      = rd_valid_q && rd_ready_i;
    last_xfer = xfer && (state_q == StSend) && (idx_q == LastIdx);
    // A strobe is taken when idle, or when the last word leaves on the same edge.
    accept    = filt_strobe_i && enable_i && ((state_q == StIdle) || last_xfer);
    drop      = filt_strobe_i && (state_q != StIdle) && !last_xfer;
    idx_nxt   = idx_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_chan_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      overrun_q  <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        shadow_q[k] <= '0;
      end
`ifdef CIC_READOUT_HEADER_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      // Set has priority over clear.
      if (clear_overrun_i) overrun_q <= 1'b0;
      if (drop)            overrun_q <= 1'b1;

      if (accept) begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          shadow_q[k] <= filt_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
        rd_valid_q <= 1'b1;
        idx_q      <= '0;
`ifdef CIC_READOUT_HEADER_EN
        state_q     <= StHdr;
        rd_chan_q   <= HEADER_CHAN;
        rd_data_q   <= DATA_WIDTH'(frame_cnt_q);
        rd_last_q   <= 1'b0;
        frame_cnt_q <= frame_cnt_q + 1'b1;
`else
        state_q   <= StSend;
        rd_chan_q <= '0;
        rd_data_q <= filt_data_i[0 +: DATA_WIDTH];
        rd_last_q <= (NUM_CHANNELS == 1);
`endif
      end else if (xfer) begin
        unique case (state_q)
`ifdef CIC_READOUT_HEADER_EN
          StHdr: begin
            state_q   <= StSend;
            idx_q     <= '0;
            rd_chan_q <= '0;
            rd_data_q <= shadow_q[0];
            rd_last_q <= (NUM_CHANNELS == 1);
          end
`endif
          StSend: begin
            if (idx_q == LastIdx) begin
              state_q    <= StIdle;
              idx_q      <= '0;
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
            end else begin
              idx_q     <= idx_nxt;
              rd_chan_q <= idx_nxt;
              rd_data_q <= shadow_q[idx_nxt];
              rd_last_q <= (idx_nxt == LastIdx);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_chan_o  = rd_chan_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_cic_row_readout.sv
// Directed bench for cic_row_readout. Builds with or without
// CIC_READOUT_HEADER_EN; the expected frame layout follows the build.
module tb_cic_row_readout;

  localparam int NCH = 24;
  localparam int DW  = 25;
`ifdef CIC_READOUT_HEADER_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NCH*DW-1:0]   filt_data;
  logic                filt_strobe;
  logic                enable;
  logic                clear_overrun;
  logic [DW-1:0]       rd_data;
  logic [4:0]          rd_chan;
  logic                rd_valid;
  logic                rd_ready;
  logic                rd_last;
  logic                overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int hdr_seen = 0;
  int vcyc;

  always #5 clk = ~clk;

  cic_row_readout #(
    .NUM_CHANNELS (NCH),
    .DATA_WIDTH   (DW)
  ) u_dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .filt_data_i     (filt_data),
    .filt_strobe_i   (filt_strobe),
    .enable_i        (enable),
    .clear_overrun_i (clear_overrun),
    .rd_data_o       (rd_data),
    .rd_chan_o       (rd_chan),
    .rd_valid_o      (rd_valid),
    .rd_ready_i      (rd_ready),
    .rd_last_o       (rd_last),
    .overrun_o       (overrun)
  );

  always @(negedge clk) begin
    if (rd_valid && rd_chan == 5'h1F) hdr_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Channel k carries base + k + 1.
  function automatic logic [NCH*DW-1:0] pattern(input int base);
    logic [NCH*DW-1:0] p;
    for (int k = 0; k < NCH; k++) p[k*DW +: DW] = DW'(base + k + 1);
    return p;
  endfunction

  // Called at a negedge; the strobe is sampled on the following posedge.
  task automatic send(input int base);
    filt_data   = pattern(base);
    filt_strobe = 1'b1;
  endtask

  // Receives one captured frame. toggle: rd_ready 0,1,0,1... starting at 0.
  // inj_at >= 0: raise a strobe with pattern(inj_base) on the cycle word inj_at transfers.
  task automatic rx_frame(input int base, input bit toggle, input int inj_at,
                          input int inj_base, output int vcnt);
    int w;
    int cyc;
    bit rdy;
    w    = HdrEn ? -1 : 0;
    cyc  = 0;
    vcnt = 0;
    @(negedge clk);
    filt_strobe = 1'b0;
    check_eq("first_word_latency", rd_valid, 1);
    while (w < NCH && cyc < 200) begin
      if (cyc > 0) begin
        @(negedge clk);
        filt_strobe = 1'b0;
      end
      cyc++;
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rd_valid) vcnt++;
      check_eq("valid", rd_valid, 1);
      if (w < 0) begin
        check_eq("hdr_chan", rd_chan, 32'h1F);
        check_eq("hdr_count", rd_data, exp_cnt % 256);
        check_eq("hdr_last", rd_last, 0);
      end else begin
        check_eq("chan", rd_chan, w);
        check_eq("data", rd_data, base + w + 1);
        check_eq("last", rd_last, (w == NCH - 1));
      end
      rd_ready = rdy;
      if (rdy) begin
        if (w == inj_at) send(inj_base);
        w++;
      end
    end
    check_eq("frame_timeout", (cyc < 200), 1);
    exp_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    filt_data     = '0;
    filt_strobe   = 1'b0;
    enable        = 1'b1;
    clear_overrun = 1'b0;
    rd_ready      = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_last", rd_last, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_data", rd_data, 0);
    check_eq("rst_chan", rd_chan, 0);
    reset_n = 1'b1;

    // Basic frame, values 1..24, ready held high.
    @(negedge clk);
    send(0);
    rx_frame(0, 1'b0, -1, 0, vcyc);
    @(negedge clk);
    check_eq("idle_after_frame", rd_valid, 0);

    // Stalling consumer: every word held until accepted.
    send(1000);
    rx_frame(1000, 1'b1, -1, 0, vcyc);
    check_eq("toggle_frame_cycles", vcyc, 48 + (HdrEn ? 2 : 0));
    @(negedge clk);
    check_eq("idle_after_toggle", rd_valid, 0);

    // Strobe mid-frame is dropped; remaining words stay from the old frame.
    check_eq("overrun_before_drop", overrun, 0);
    send(2000);
    rx_frame(2000, 1'b0, 10, 3000, vcyc);
    @(negedge clk);
    check_eq("overrun_after_drop", overrun, 1);
    check_eq("idle_after_drop", rd_valid, 0);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check_eq("overrun_cleared", overrun, 0);

    // Strobe on the last-word transfer starts the next frame back to back.
    send(4000);
    rx_frame(4000, 1'b0, NCH - 1, 5000, vcyc);
    rx_frame(5000, 1'b0, -1, 0, vcyc);
    check_eq("overrun_back_to_back", overrun, 0);
    @(negedge clk);
    check_eq("idle_after_b2b", rd_valid, 0);

    // Enable low: strobe ignored, no overrun.
    enable = 1'b0;
    send(6000);
    @(negedge clk);
    filt_strobe = 1'b0;
    check_eq("disabled_valid", rd_valid, 0);
    check_eq("disabled_overrun", overrun, 0);
    @(negedge clk);
    check_eq("disabled_valid2", rd_valid, 0);
    enable = 1'b1;

    // Asynchronous reset mid-frame.
    send(7000);
    rd_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      filt_strobe = 1'b0;
    end
    check_eq("pre_reset_chan", rd_chan, 32'(HdrEn ? 4 : 5));
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", rd_valid, 0);
    check_eq("async_rst_data", rd_data, 0);
    check_eq("async_rst_chan", rd_chan, 0);
    exp_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("post_reset_idle", rd_valid, 0);
    end
    // Strobe presented right at release is taken on the first edge.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    send(8000);
    rx_frame(8000, 1'b0, -1, 0, vcyc);

`ifdef CIC_READOUT_HEADER_EN
    // Counter wraps after 256 frames.
    reset_n = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int f = 0; f < 257; f++) begin
      send(f * 10);
      rx_frame(f * 10, 1'b0, -1, 0, vcyc);
      @(negedge clk);
    end
`else
    check_eq("no_header_words", hdr_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
